// File: rtl/washing_machine.sv
// Front-load washing machine sequencer: lock, fill, soap, wash, drain, spin, done.
// Optional watchdog with ERROR state enabled by defining WM_WATCHDOG_EN.
module washing_machine #(
   parameter int WDOG_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic door,
   input  logic filled,
   input  logic detergent_add,
   input  logic cycle_timeout,
   input  logic drained,
   input  logic spin,
   output logic lock,
   output logic water_valve,
   output logic water_wash,
   output logic soap_wash,
   output logic motor,
   output logic drain_valve,
   output logic done,
   output logic error
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_SOAP  = 3'd2,
      S_WASH  = 3'd3,
      S_DRAIN = 3'd4,
      S_SPIN  = 3'd5,
      S_DONE  = 3'd6
`ifdef WM_WATCHDOG_EN
      ,S_ERROR = 3'd7
`endif
   } state_t;

   // Output bits: {lock, water_valve, water_wash, soap_wash, motor, drain_valve, done, error}
   function automatic logic [7:0] decode_outputs(input state_t s);
      logic [7:0] o;
      case (s)
         S_IDLE:  o = 8'b0000_0000;
         S_FILL:  o = 8'b1100_0000;
         S_SOAP:  o = 8'b1001_0000;
         S_WASH:  o = 8'b1010_1000;
         S_DRAIN: o = 8'b1000_0100;
         S_SPIN:  o = 8'b1000_1100;
         S_DONE:  o = 8'b0000_0010;
`ifdef WM_WATCHDOG_EN
         S_ERROR: o = 8'b1000_0101;
`endif
         default: o = 8'b0000_0000;
      endcase
      return o;
   endfunction

   if (WDOG_CYCLES < 2) begin : g_wdog_param_check
      $error("WDOG_CYCLES must be at least 2");
   end

   state_t     state_q;
   state_t     state_d;
   logic [7:0] out_q;

`ifdef WM_WATCHDOG_EN
   localparam int CW = $clog2(WDOG_CYCLES) + 1;
   localparam logic [CW-1:0] WDOG_LAST = CW'(WDOG_CYCLES - 1);
   logic [CW-1:0] wdog_q;
   logic          wait_state_s;
`endif

   // Next-state logic; each state holds until its own exit input is seen.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start && door) state_d = S_FILL;
            else               state_d = S_IDLE;
         end
         S_FILL: begin
            if (filled) state_d = S_SOAP;
            else        state_d = S_FILL;
         end
         S_SOAP: begin
            if (detergent_add) state_d = S_WASH;
            else               state_d = S_SOAP;
         end
         S_WASH: begin
            if (cycle_timeout) state_d = S_DRAIN;
            else               state_d = S_WASH;
         end
         S_DRAIN: begin
            if (drained) state_d = S_SPIN;
            else         state_d = S_DRAIN;
         end
         S_SPIN: begin
            if (spin) state_d = S_DONE;
            else      state_d = S_SPIN;
         end
         S_DONE: begin
            if (!start) state_d = S_IDLE;
            else        state_d = S_DONE;
         end
`ifdef WM_WATCHDOG_EN
         S_ERROR: begin
            if (drained && !start) state_d = S_IDLE;
            else                   state_d = S_ERROR;
         end
`endif
         default: state_d = S_IDLE;
      endcase
`ifdef WM_WATCHDOG_EN
      // A stalled wait state with an expired budget is forced to ERROR.
      if (wait_state_s && (wdog_q == WDOG_LAST) && (state_d == state_q)) begin
         state_d = S_ERROR;
      end else begin
         state_d = state_d;
      end
`endif
   end

`ifdef WM_WATCHDOG_EN
   // Marks the states in which the watchdog budget is consumed.
   always_comb begin
      case (state_q)
         S_FILL, S_SOAP, S_WASH, S_DRAIN, S_SPIN: wait_state_s = 1'b1;
         default:                                 wait_state_s = 1'b0;
      endcase
   end

   // Watchdog counter: clears on any state change, saturates at the limit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wdog_q <= '0;
      end else if (state_d != state_q) begin
         wdog_q <= '0;
      end else if (wait_state_s && (wdog_q != WDOG_LAST)) begin
         wdog_q <= wdog_q + 1'b1;
      end else begin
         wdog_q <= wdog_q;
      end
   end
`endif

   // State register with outputs decoded from the next state so they align with state_q.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         out_q   <= 8'b0000_0000;
      end else begin
         state_q <= state_d;
         out_q   <= decode_outputs(state_d);
      end
   end

   assign lock        = out_q[7];
   assign water_valve = out_q[6];
   assign water_wash  = out_q[5];
   assign soap_wash   = out_q[4];
   assign motor       = out_q[3];
   assign drain_valve = out_q[2];
   assign done        = out_q[1];
`ifdef WM_WATCHDOG_EN
   assign error       = out_q[0];
`else
   assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_washing_machine.sv
// Directed self-checking bench for washing_machine (watchdog test runs when WM_WATCHDOG_EN is defined).
`timescale 1ns/1ps
module tb_washing_machine;

   localparam logic [7:0] O_IDLE  = 8'b0000_0000;
   localparam logic [7:0] O_FILL  = 8'b1100_0000;
   localparam logic [7:0] O_SOAP  = 8'b1001_0000;
   localparam logic [7:0] O_WASH  = 8'b1010_1000;
   localparam logic [7:0] O_DRAIN = 8'b1000_0100;
   localparam logic [7:0] O_SPIN  = 8'b1000_1100;
   localparam logic [7:0] O_DONE  = 8'b0000_0010;
   localparam logic [7:0] O_ERR   = 8'b1000_0101;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0, door = 1'b0;
   logic [4:0] sens = 5'b00000; // {filled, detergent_add, cycle_timeout, drained, spin}
   logic lock, water_valve, water_wash, soap_wash, motor, drain_valve, done, error;
   logic [7:0] outs;
   int n_cmp = 0;
   int n_bad = 0;

   assign outs = {lock, water_valve, water_wash, soap_wash, motor, drain_valve, done, error};

   always #5 clk = ~clk;

   washing_machine #(.WDOG_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .start(start), .door(door),
      .filled(sens[4]), .detergent_add(sens[3]), .cycle_timeout(sens[2]),
      .drained(sens[1]), .spin(sens[0]),
      .lock(lock), .water_valve(water_valve), .water_wash(water_wash),
      .soap_wash(soap_wash), .motor(motor), .drain_valve(drain_valve),
      .done(done), .error(error)
   );

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      tick(1);
      rst = 1'b1; start = 1'b0; door = 1'b0; sens = 5'b00000;
      tick(1);
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b1; door = 1'b1; sens = 5'b11111;
      tick(2);
      n_cmp++;
      if (outs !== O_IDLE) begin
         n_bad++; $display("FAIL reset_hold got=%b want=%b", outs, O_IDLE);
      end
      rst = 1'b1; start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick(1);
         n_cmp++;
         if (outs !== O_IDLE) begin
            n_bad++; $display("FAIL reset_release[%0d] got=%b want=%b", i, outs, O_IDLE);
         end
      end
   endtask

   task automatic test_nominal();
      logic [7:0] exp_t [0:4];
      exp_t[0] = O_SOAP; exp_t[1] = O_WASH; exp_t[2] = O_DRAIN;
      exp_t[3] = O_SPIN; exp_t[4] = O_DONE;
      sens = 5'b00000; start = 1'b1; door = 1'b1;
      tick(1);
      n_cmp++;
      if (outs !== O_FILL) begin
         n_bad++; $display("FAIL nominal_fill got=%b want=%b", outs, O_FILL);
      end
      tick(9);
      n_cmp++;
      if (outs !== O_FILL) begin
         n_bad++; $display("FAIL nominal_fill_wait got=%b want=%b", outs, O_FILL);
      end
      for (int k = 0; k < 5; k++) begin
         sens[4-k] = 1'b1;
         tick(1);
         n_cmp++;
         if (outs !== exp_t[k]) begin
            n_bad++; $display("FAIL nominal_step[%0d] got=%b want=%b", k, outs, exp_t[k]);
         end
         tick(9);
         n_cmp++;
         if (outs !== exp_t[k]) begin
            n_bad++; $display("FAIL nominal_hold[%0d] got=%b want=%b", k, outs, exp_t[k]);
         end
      end
      start = 1'b0;
      tick(1);
      n_cmp++;
      if (outs !== O_IDLE) begin
         n_bad++; $display("FAIL nominal_done_exit got=%b want=%b", outs, O_IDLE);
      end
      sens = 5'b00000;
   endtask

   task automatic test_door();
      start = 1'b1; door = 1'b0; sens = 5'b00000;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         n_cmp++;
         if (outs !== O_IDLE) begin
            n_bad++; $display("FAIL door_open_idle[%0d] got=%b want=%b", i, outs, O_IDLE);
         end
      end
      door = 1'b1;
      tick(1);
      n_cmp++;
      if (outs !== O_FILL) begin
         n_bad++; $display("FAIL door_closed_fill got=%b want=%b", outs, O_FILL);
      end
      sens[4] = 1'b1; tick(1);
      sens[3] = 1'b1; tick(1);
      door = 1'b0;
      tick(3);
      n_cmp++;
      if (outs !== O_WASH) begin
         n_bad++; $display("FAIL door_ignored_wash got=%b want=%b", outs, O_WASH);
      end
      apply_reset();
   endtask

   task automatic test_preasserted();
      logic [7:0] seq_t [0:5];
      seq_t[0] = O_FILL; seq_t[1] = O_SOAP; seq_t[2] = O_WASH;
      seq_t[3] = O_DRAIN; seq_t[4] = O_SPIN; seq_t[5] = O_DONE;
      sens = 5'b11111;
      tick(1);
      start = 1'b1; door = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick(1);
         n_cmp++;
         if (outs !== seq_t[k]) begin
            n_bad++; $display("FAIL preasserted[%0d] got=%b want=%b", k, outs, seq_t[k]);
         end
      end
      start = 1'b0;
      tick(1);
      n_cmp++;
      if (outs !== O_IDLE) begin
         n_bad++; $display("FAIL preasserted_idle got=%b want=%b", outs, O_IDLE);
      end
      sens = 5'b00000;
   endtask

   task automatic test_mid_reset();
      sens = 5'b00000; start = 1'b1; door = 1'b1;
      tick(1);
      sens[4] = 1'b1; tick(1);
      sens[3] = 1'b1; tick(1);
      n_cmp++;
      if (outs !== O_WASH) begin
         n_bad++; $display("FAIL midrst_reach_wash got=%b want=%b", outs, O_WASH);
      end
      rst = 1'b0;
      tick(1);
      n_cmp++;
      if (outs !== O_IDLE) begin
         n_bad++; $display("FAIL midrst_all_zero got=%b want=%b", outs, O_IDLE);
      end
      rst = 1'b1; start = 1'b0;
      tick(1);
      n_cmp++;
      if (outs !== O_IDLE) begin
         n_bad++; $display("FAIL midrst_release got=%b want=%b", outs, O_IDLE);
      end
      sens = 5'b00000;
   endtask

   task automatic test_watchdog();
      sens = 5'b00000; start = 1'b1; door = 1'b1;
      tick(1);
      tick(15);
`ifdef WM_WATCHDOG_EN
      n_cmp++;
      if (outs !== O_FILL) begin
         n_bad++; $display("FAIL wdog_before_limit got=%b want=%b", outs, O_FILL);
      end
      tick(1);
      n_cmp++;
      if (outs !== O_ERR) begin
         n_bad++; $display("FAIL wdog_error got=%b want=%b", outs, O_ERR);
      end
      start = 1'b0;
      tick(2);
      n_cmp++;
      if (outs !== O_ERR) begin
         n_bad++; $display("FAIL wdog_error_hold got=%b want=%b", outs, O_ERR);
      end
      sens[1] = 1'b1;
      tick(1);
      n_cmp++;
      if (outs !== O_IDLE) begin
         n_bad++; $display("FAIL wdog_recover got=%b want=%b", outs, O_IDLE);
      end
`else
      tick(30);
      n_cmp++;
      if (outs !== O_FILL) begin
         n_bad++; $display("FAIL nowdog_wait_forever got=%b want=%b", outs, O_FILL);
      end
`endif
      apply_reset();
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_door();
      test_preasserted();
      test_mid_reset();
      test_watchdog();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/washing_machine.md
Name: washing_machine

Overview:
Moore-style controller for a front-load washing machine. It sequences door lock, water fill, detergent request, wash agitation, drain and spin from a small set of handshake/sensor inputs. It sits between the user panel (start, door) and the appliance actuators/sensors. All outputs are decoded from a registered state.

Parameters:
WDOG_CYCLES, 1024, watchdog limit in clocks per wait state; used only when WM_WATCHDOG_EN is defined.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-low reset (rst=0 at a rising edge resets)
start  input  1  user start request, level
door  input  1  1 = door closed
filled  input  1  water level sensor, 1 = tub full
detergent_add  input  1  1 = detergent has been dispensed
cycle_timeout  input  1  1 = wash agitation time elapsed
drained  input  1  1 = tub empty
spin  input  1  1 = spin phase complete
lock  output  1  door lock solenoid
water_valve  output  1  fill valve open
water_wash  output  1  water wash (agitation in water) active
soap_wash  output  1  detergent request / soap phase active
motor  output  1  drum motor on
drain_valve  output  1  drain valve open
done  output  1  program finished
error  output  1  watchdog fault; tied 0 when WM_WATCHDOG_EN undefined

Behaviour:
- One clock domain: clk. Reset: rst synchronous, active-low. On reset, state=IDLE and all outputs 0.
- States and exits (evaluated at each rising edge, one transition per edge max):
  IDLE: start=1 and door=1 -> FILL; otherwise stay.
  FILL: filled=1 -> SOAP.
  SOAP: detergent_add=1 -> WASH.
  WASH: cycle_timeout=1 -> DRAIN.
  DRAIN: drained=1 -> SPIN.
  SPIN: spin=1 -> DONE.
  DONE: start=0 -> IDLE; stay while start=1 (no auto-restart on held start).
- Output decode (pure function of state, no input combinational paths):
  IDLE: all 0.
  FILL: lock, water_valve.
  SOAP: lock, soap_wash.
  WASH: lock, motor, water_wash.
  DRAIN: lock, drain_valve.
  SPIN: lock, motor, drain_valve.
  DONE: done only (lock released).
- Latency: condition sampled at edge N -> new state and outputs valid after edge N. Every state is occupied for at least one cycle even if its exit input is already 1 on entry.
- Inputs irrelevant to current state are ignored (e.g. filled while in WASH).
- door ignored after leaving IDLE (door is locked); door=0 in IDLE blocks start.
- Reset mid-operation: any state -> IDLE next edge, all outputs 0 including lock.
- Unused/illegal state encodings -> IDLE.
- State encoding free; 3-bit binary minimum, plus ERROR when watchdog is enabled.

Optional Feature:
WM_WATCHDOG_EN
- Defined: a counter clears on every state change and increments each cycle in FILL, SOAP, WASH, DRAIN, SPIN. When it reaches WDOG_CYCLES-1 without an exit, next state is ERROR. ERROR outputs: error=1, drain_valve=1, lock=1, all others 0. ERROR exits to IDLE only when drained=1 and start=0. Counter saturates, and clears on reset.
- Undefined: no counter, no ERROR state, error tied 0. The FSM waits indefinitely in each state.

Test Plan:
- Reset: rst=0 for 2 edges with all inputs 1 -> all outputs 0, state IDLE; release rst=1 with start=0 -> outputs stay 0.
- Nominal run: start=1, door=1, then raise filled, detergent_add, cycle_timeout, drained, spin in turn, 10 cycles apart. Each edge after a raise advances one state. Check FILL {lock,water_valve}=11, SOAP soap_wash=1, WASH {motor,water_wash}=11, DRAIN drain_valve=1, SPIN {motor,drain_valve}=11, DONE done=1 lock=0. Holding start=1 keeps DONE; dropping start gives IDLE next edge.
- Door interlock: start=1, door=0 for 5 cycles -> stays IDLE, lock=0. Set door=1 -> FILL after next edge. Later door=0 in WASH -> no effect.
- All sensors pre-asserted: filled=detergent_add=cycle_timeout=drained=spin=1, then start=door=1 -> FILL, SOAP, WASH, DRAIN, SPIN, DONE on six consecutive edges, one cycle each.
- Mid-cycle reset: reach WASH, assert rst=0 for one edge -> next cycle motor=0, lock=0, all 0. Release reset -> IDLE.
- Watchdog (WM_WATCHDOG_EN, WDOG_CYCLES=16): enter FILL and hold filled=0 -> error=1, drain_valve=1 after 16 cycles in FILL. drained=1 and start=0 -> IDLE.
